// File: rtl/ref_pix_ar_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// ref_pix_ar_issue_ctrl_if
// Bundles the handshake and bus signals that the reference-pixel AR issue
// controller exchanges with its neighbours:
//   - AR FIFO read side   : ar_fifo_empty, ar_fifo_dout, ar_fifo_rd_en
//   - AXI read address    : axi_arvalid, axi_araddr, axi_arlen, axi_arready
//   - AXI read data       : axi_rvalid, axi_rlast, axi_rready
//   - cache fill handshake: fill_ready, fill_done
// The master modport is the controller's view; the slave modport is the
// view of the surrounding FIFO / interconnect / fill logic.
// ---------------------------------------------------------------------------
interface ref_pix_ar_issue_ctrl_if #(
    parameter int AXI_ADDR_WDTH = 32
);
    logic                     ar_fifo_empty;
    logic [AXI_ADDR_WDTH-1:0] ar_fifo_dout;
    logic                     ar_fifo_rd_en;

    logic                     axi_arvalid;
    logic [AXI_ADDR_WDTH-1:0] axi_araddr;
    logic [7:0]               axi_arlen;
    logic                     axi_arready;

    logic                     axi_rvalid;
    logic                     axi_rlast;
    logic                     axi_rready;

    logic                     fill_ready;
    logic                     fill_done;

    // Controller side
    modport master (
        input  ar_fifo_empty,
        input  ar_fifo_dout,
        output ar_fifo_rd_en,
        output axi_arvalid,
        output axi_araddr,
        output axi_arlen,
        input  axi_arready,
        input  axi_rvalid,
        input  axi_rlast,
        output axi_rready,
        input  fill_ready,
        output fill_done
    );

    // FIFO / interconnect / fill-logic side
    modport slave (
        output ar_fifo_empty,
        output ar_fifo_dout,
        input  ar_fifo_rd_en,
        input  axi_arvalid,
        input  axi_araddr,
        input  axi_arlen,
        output axi_arready,
        output axi_rvalid,
        output axi_rlast,
        input  axi_rready,
        output fill_ready,
        input  fill_done
    );
endinterface

// File: rtl/ref_pix_ar_issue_ctrl.sv
// ---------------------------------------------------------------------------
// ref_pix_ar_issue_ctrl
// Miss-path sequencer for the reference-pixel cache. Pops line-miss
// addresses from the AR FIFO, issues each one as a fixed-length AXI read
// burst, limits the number of bursts in flight, and watches the R channel
// so that every completed burst produces exactly one fill_done pulse.
//
// Ports:
//   clk             clock
//   reset           asynchronous active-high reset
//   issue_enable    1 = new bursts may start; 0 = only finish the current AR
//   bus             ref_pix_ar_issue_ctrl_if.master (FIFO, AR, R, fill)
//   outstanding_cnt bursts issued but not yet completed
//   busy            FSM not IDLE or bursts still in flight
//   protocol_err    sticky R-channel protocol violation flag
// ---------------------------------------------------------------------------
module ref_pix_ar_issue_ctrl #(
    parameter int AXI_ADDR_WDTH   = 32,
    parameter int BURST_LEN       = 8,
    parameter int MAX_OUTSTANDING = 4,   // legal range 1..15
    parameter int ADDR_ALIGN      = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_enable,
    ref_pix_ar_issue_ctrl_if.master        bus,
    output logic [3:0]                     outstanding_cnt,
    output logic                           busy,
    output logic                           protocol_err
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0]        LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [3:0]               MAX_OUT    = 4'(MAX_OUTSTANDING);
    localparam logic [AXI_ADDR_WDTH-1:0] ALIGN_MASK =
        ~((AXI_ADDR_WDTH'(1) << ADDR_ALIGN) - AXI_ADDR_WDTH'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic                       rd_en_q;
    logic [AXI_ADDR_WDTH-1:0]   araddr_q;
    logic [BEAT_W-1:0]          beat_cnt;
    logic                       fill_done_q;

    logic                       can_issue;
    logic                       pop_start;
    logic                       addr_load;
    logic                       arvalid;
    logic                       ar_hs;

    logic                       r_beat;
    logic                       r_orphan;
    logic                       r_counted;
    logic                       burst_end;
    logic                       len_err;

    // A new burst may only start when allowed, there is a miss waiting and
    // the in-flight budget has room left.
    assign can_issue = issue_enable && !bus.ar_fifo_empty
                       && (outstanding_cnt < MAX_OUT);

    // State register for the issue FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. POP spans two cycles: the cycle carrying the pop
    // strobe, then the cycle where the FIFO data is valid and gets captured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_issue)       state_d = POP;
            POP:     if (!rd_en_q)        state_d = ISSUE;
            ISSUE:   if (bus.axi_arready) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // FSM output decode: pop request, address capture and AR valid.
    always_comb begin
        pop_start = 1'b0;
        addr_load = 1'b0;
        arvalid   = 1'b0;
        case (state_q)
            IDLE:    pop_start = can_issue;
            POP:     addr_load = !rd_en_q;
            ISSUE:   arvalid   = 1'b1;
            default: ;
        endcase
    end

    assign ar_hs = arvalid && bus.axi_arready;

    // Pop strobe is registered so it is a clean one-cycle pulse; the address
    // is aligned to the cache line as it is captured and then held until
    // the AR handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en_q  <= 1'b0;
            araddr_q <= '0;
        end else begin
            rd_en_q <= pop_start;
            if (addr_load) begin
                araddr_q <= bus.ar_fifo_dout & ALIGN_MASK;
            end
        end
    end

    // R-channel classification. A beat with nothing in flight is an orphan:
    // it is flagged but not counted, so it cannot retire a real burst.
    always_comb begin
        r_beat    = bus.axi_rvalid && bus.fill_ready;
        r_orphan  = r_beat && (outstanding_cnt == 4'd0);
        r_counted = r_beat && !r_orphan;
        burst_end = r_counted && bus.axi_rlast;
        len_err   = (burst_end && (beat_cnt != LAST_BEAT))
                    || (r_counted && !bus.axi_rlast && (beat_cnt == LAST_BEAT));
    end

    // Beat counter restarts on RLAST, and also after a full-length burst
    // that lacked RLAST so the next burst starts counting from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (r_counted) begin
            if (bus.axi_rlast || (beat_cnt == LAST_BEAT)) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
        end
    end

    // In-flight burst counter. An AR handshake and a burst completion in
    // the same cycle cancel out. Decrements only come from counted beats,
    // so the counter cannot wrap below zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_cnt <= 4'd0;
        end else begin
            case ({ar_hs, burst_end})
                2'b10: if (outstanding_cnt < MAX_OUT)
                           outstanding_cnt <= outstanding_cnt + 4'd1;
                2'b01: outstanding_cnt <= outstanding_cnt - 4'd1;
                default: ;
            endcase
        end
    end

    // One registered fill_done pulse per completed burst, and the sticky
    // protocol error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_done_q  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            fill_done_q <= burst_end;
            if (r_orphan || len_err) begin
                protocol_err <= 1'b1;
            end
        end
    end

    assign bus.ar_fifo_rd_en = rd_en_q;
    assign bus.axi_arvalid   = arvalid;
    assign bus.axi_araddr    = araddr_q;
    assign bus.axi_arlen     = 8'(BURST_LEN - 1);
    assign bus.axi_rready    = bus.fill_ready;
    assign bus.fill_done     = fill_done_q;
    assign busy              = (state_q != IDLE) || (outstanding_cnt != 4'd0);

endmodule

// File: tb/tb_ref_pix_ar_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ref_pix_ar_issue_ctrl
// Directed bench for the reference-pixel AR issue controller. A small FIFO
// model feeds miss addresses; AR ready and R beats are driven directly.
// ---------------------------------------------------------------------------
module tb_ref_pix_ar_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       issue_enable = 1'b0;
    logic [3:0] outstanding_cnt;
    logic       busy;
    logic       protocol_err;

    ref_pix_ar_issue_ctrl_if #(.AXI_ADDR_WDTH(32)) bus ();

    ref_pix_ar_issue_ctrl #(
        .AXI_ADDR_WDTH  (32),
        .BURST_LEN      (8),
        .MAX_OUTSTANDING(4),
        .ADDR_ALIGN     (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_enable   (issue_enable),
        .bus            (bus),
        .outstanding_cnt(outstanding_cnt),
        .busy           (busy),
        .protocol_err   (protocol_err)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on dout the cycle after the pop strobe.
    logic [31:0] fifo_mem [0:31];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign bus.ar_fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.ar_fifo_rd_en) begin
            bus.ar_fifo_dout <= fifo_mem[rd_ptr % 32];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    // Event counters for AR handshakes and FIFO pops seen at clock edges.
    int hs_seen  = 0;
    int pop_seen = 0;

    always @(posedge clk) begin
        if (bus.axi_arvalid && bus.axi_arready) hs_seen++;
        if (bus.ar_fifo_rd_en) pop_seen++;
    end

    int vectors     = 0;
    int miscompares = 0;
    int h0;
    int p0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                     tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushAddr(input logic [31:0] a);
        fifo_mem[wr_ptr % 32] = a;
        wr_ptr++;
    endtask

    task automatic applyStimulus(input logic rvalid, input logic rlast);
        bus.axi_rvalid = rvalid;
        bus.axi_rlast  = rlast;
    endtask

    // Drive n consecutive R beats; rlast on beat number last_at (0 = never).
    task automatic sendBeats(input int n, input int last_at);
        for (int i = 1; i <= n; i++) begin
            applyStimulus(1'b1, i == last_at);
            tick();
        end
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic waitArvalid(input string tag);
        int k = 0;
        while (!bus.axi_arvalid && k < 20) begin
            tick();
            k++;
        end
        checkOutput(tag, bus.axi_arvalid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.axi_arready = 1'b0;
        bus.fill_ready  = 1'b1;
        applyStimulus(1'b0, 1'b0);

        // Reset values
        tick(2);
        checkOutput("rst_rd_en",   bus.ar_fifo_rd_en, 1'b0);
        checkOutput("rst_arvalid", bus.axi_arvalid,   1'b0);
        checkOutput("rst_araddr",  bus.axi_araddr,    32'h0);
        checkOutput("rst_cnt",     outstanding_cnt,   4'd0);
        checkOutput("rst_fill",    bus.fill_done,     1'b0);
        checkOutput("rst_err",     protocol_err,      1'b0);
        checkOutput("rst_busy",    busy,              1'b0);
        checkOutput("arlen",       bus.axi_arlen,     8'd7);
        bus.fill_ready = 1'b0;
        #1;
        checkOutput("rready_lo", bus.axi_rready, 1'b0);
        bus.fill_ready = 1'b1;
        #1;
        checkOutput("rready_hi", bus.axi_rready, 1'b1);
        tick();
        reset = 1'b0;
        tick();

        // Single miss
        pushAddr(32'h0001_2345);
        issue_enable    = 1'b1;
        bus.axi_arready = 1'b1;
        tick();
        checkOutput("s1_rd_en_c1",   bus.ar_fifo_rd_en, 1'b1);
        checkOutput("s1_arvalid_c1", bus.axi_arvalid,   1'b0);
        checkOutput("s1_busy_c1",    busy,              1'b1);
        tick();
        checkOutput("s1_rd_en_c2",   bus.ar_fifo_rd_en, 1'b0);
        checkOutput("s1_arvalid_c2", bus.axi_arvalid,   1'b0);
        tick();
        checkOutput("s1_arvalid_c3", bus.axi_arvalid,   1'b1);
        checkOutput("s1_araddr",     bus.axi_araddr,    32'h0001_2340);
        checkOutput("s1_cnt_c3",     outstanding_cnt,   4'd0);
        tick();
        checkOutput("s1_arvalid_c4", bus.axi_arvalid,   1'b0);
        checkOutput("s1_cnt_c4",     outstanding_cnt,   4'd1);
        sendBeats(7, 0);
        checkOutput("s1_fill_early", bus.fill_done,     1'b0);
        checkOutput("s1_cnt_mid",    outstanding_cnt,   4'd1);
        sendBeats(1, 1);
        checkOutput("s1_fill_done",  bus.fill_done,     1'b1);
        checkOutput("s1_cnt_end",    outstanding_cnt,   4'd0);
        checkOutput("s1_busy_end",   busy,              1'b0);
        checkOutput("s1_err",        protocol_err,      1'b0);
        tick();
        checkOutput("s1_fill_pulse", bus.fill_done,     1'b0);

        // Backpressure on AR
        bus.axi_arready = 1'b0;
        pushAddr(32'h0000_ABCF);
        pushAddr(32'h1234_5678);
        tick(3);
        checkOutput("s2_arvalid", bus.axi_arvalid, 1'b1);
        checkOutput("s2_araddr",  bus.axi_araddr,  32'h0000_ABC0);
        p0 = pop_seen;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("s2_hold_valid", bus.axi_arvalid, 1'b1);
            checkOutput("s2_hold_addr",  bus.axi_araddr,  32'h0000_ABC0);
            checkOutput("s2_hold_cnt",   outstanding_cnt, 4'd0);
        end
        checkOutput("s2_no_pop", pop_seen - p0, 32'd0);
        bus.axi_arready = 1'b1;
        tick();
        checkOutput("s2_hs_valid", bus.axi_arvalid, 1'b0);
        checkOutput("s2_hs_cnt",   outstanding_cnt, 4'd1);
        tick();
        checkOutput("s2_rd_en2",   bus.ar_fifo_rd_en, 1'b1);
        tick(2);
        checkOutput("s2_araddr2",  bus.axi_araddr,  32'h1234_5640);
        tick();
        checkOutput("s2_cnt2",     outstanding_cnt, 4'd2);
        sendBeats(8, 8);
        sendBeats(8, 8);
        checkOutput("s2_drain_cnt", outstanding_cnt, 4'd0);
        checkOutput("s2_err",       protocol_err,    1'b0);

        // Outstanding limit
        h0 = hs_seen;
        p0 = pop_seen;
        for (int i = 0; i < 6; i++) pushAddr(32'h0004_0000 + 32'(i) * 32'h100);
        tick(30);
        checkOutput("s3_hs4",   hs_seen - h0,    32'd4);
        checkOutput("s3_pop4",  pop_seen - p0,   32'd4);
        checkOutput("s3_cnt4",  outstanding_cnt, 4'd4);
        bus.axi_arready = 1'b0;
        sendBeats(8, 8);
        tick(10);
        checkOutput("s3_pop5",     pop_seen - p0,   32'd5);
        checkOutput("s3_arvalid5", bus.axi_arvalid, 1'b1);
        checkOutput("s3_cnt3",     outstanding_cnt, 4'd3);
        bus.axi_arready = 1'b1;
        tick();
        checkOutput("s3_hs5",      hs_seen - h0,    32'd5);
        checkOutput("s3_cnt_back", outstanding_cnt, 4'd4);
        tick(6);
        checkOutput("s3_blocked",  pop_seen - p0,   32'd5);

        // AR handshake coinciding with an RLAST beat
        bus.axi_arready = 1'b0;
        sendBeats(8, 8);
        sendBeats(8, 8);
        checkOutput("s4_arvalid", bus.axi_arvalid, 1'b1);
        checkOutput("s4_cnt2",    outstanding_cnt, 4'd2);
        sendBeats(7, 0);
        bus.axi_arready = 1'b1;
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("s4_cnt_same", outstanding_cnt, 4'd2);
        checkOutput("s4_fill",     bus.fill_done,   1'b1);
        checkOutput("s4_ar_done",  bus.axi_arvalid, 1'b0);
        checkOutput("s4_hs6",      hs_seen - h0,    32'd6);
        sendBeats(8, 8);
        sendBeats(8, 8);
        checkOutput("s4_drain", outstanding_cnt, 4'd0);
        checkOutput("s4_err",   protocol_err,    1'b0);

        // Orphan R beat
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("s5_orphan_err",  protocol_err,    1'b1);
        checkOutput("s5_orphan_cnt",  outstanding_cnt, 4'd0);
        checkOutput("s5_orphan_fill", bus.fill_done,   1'b0);
        tick(3);
        checkOutput("s5_orphan_sticky", protocol_err, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("s5_err_clear", protocol_err, 1'b0);
        tick();
        reset = 1'b0;

        // Short burst: RLAST on beat 5
        pushAddr(32'h00FF_FFFF);
        tick(4);
        checkOutput("s5_cnt1",   outstanding_cnt, 4'd1);
        checkOutput("s5_araddr", bus.axi_araddr,  32'h00FF_FFC0);
        sendBeats(4, 0);
        checkOutput("s5_no_err_yet", protocol_err, 1'b0);
        sendBeats(1, 1);
        checkOutput("s5_short_err",  protocol_err,    1'b1);
        checkOutput("s5_short_cnt",  outstanding_cnt, 4'd0);
        checkOutput("s5_short_fill", bus.fill_done,   1'b1);
        tick(5);
        checkOutput("s5_short_sticky", protocol_err, 1'b1);

        // Asynchronous reset while in ISSUE with three bursts in flight
        pushAddr(32'hA000_0000);
        pushAddr(32'hA000_0040);
        pushAddr(32'hA000_0080);
        pushAddr(32'hA000_00C0);
        pushAddr(32'hBEEF_F00D);
        begin
            int k = 0;
            while (!(outstanding_cnt == 4'd3 && bus.axi_arvalid) && k < 60) begin
                tick();
                k++;
            end
        end
        checkOutput("s6_pre_cnt", outstanding_cnt, 4'd3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("s6_rst_arvalid", bus.axi_arvalid,   1'b0);
        checkOutput("s6_rst_araddr",  bus.axi_araddr,    32'h0);
        checkOutput("s6_rst_cnt",     outstanding_cnt,   4'd0);
        checkOutput("s6_rst_rd_en",   bus.ar_fifo_rd_en, 1'b0);
        checkOutput("s6_rst_busy",    busy,              1'b0);
        checkOutput("s6_rst_err",     protocol_err,      1'b0);
        checkOutput("s6_rst_fill",    bus.fill_done,     1'b0);
        tick();
        reset = 1'b0;
        waitArvalid("s6_resume_arvalid");
        checkOutput("s6_resume_addr", bus.axi_araddr, 32'hBEEF_F000);
        tick();
        checkOutput("s6_resume_cnt", outstanding_cnt, 4'd1);

        // Full-length burst without RLAST
        sendBeats(7, 0);
        checkOutput("s7_no_err", protocol_err, 1'b0);
        sendBeats(1, 0);
        checkOutput("s7_missing_last", protocol_err,    1'b1);
        checkOutput("s7_cnt_kept",     outstanding_cnt, 4'd1);
        sendBeats(1, 1);
        checkOutput("s7_cnt_end",  outstanding_cnt, 4'd0);
        checkOutput("s7_fill",     bus.fill_done,   1'b1);
        checkOutput("s7_sticky",   protocol_err,    1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
